slideshow_scanner: RTL and testbench

Parametrised full-frame image sequencer for the VGA adapter. It raster-scans every pixel of the framebuffer and reads the matching pixel from one of NUM_IMAGES image ROMs. Each pixel is presented to the adapter's colour/x/y/plot inputs. The displayed image advances after a programmable dwell time or on a user request. Image changes are committed only at frame boundaries, so no frame ever mixes two images.

---
 rtl/slideshow_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_slideshow_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/slideshow_scanner.sv
// slideshow_scanner: raster-scans the framebuffer and plots one of NUM_IMAGES ROM images,
// swapping images only at frame boundaries. Define SLIDESHOW_REVERSE_EN to add prev_req.
module slideshow_scanner #(
    parameter int NUM_IMAGES    = 3,
    parameter int X_MAX         = 160,
    parameter int Y_MAX         = 120,
    parameter int XW            = 8,
    parameter int YW            = 7,
    parameter int COLOUR_BITS   = 3,
    parameter int DWELL_SECONDS = 10,
    parameter int IW            = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sec_tick,
    input  logic                              next_req,
`ifdef SLIDESHOW_REVERSE_EN
    input  logic                              prev_req,
`endif
    input  logic                              pause,
    input  logic [NUM_IMAGES*COLOUR_BITS-1:0] rom_data,
    output logic [XW-1:0]                     addr_x,
    output logic [YW-1:0]                     addr_y,
    output logic [XW-1:0]                     x,
    output logic [YW-1:0]                     y,
    output logic [COLOUR_BITS-1:0]            colour,
    output logic                              plot,
    output logic [IW-1:0]                     image_sel,
    output logic                              frame_done
);

    typedef enum logic {
        SCAN,
        SWAP
    } state_t;

    localparam logic [XW-1:0] LAST_X    = XW'(X_MAX - 1);
    localparam logic [YW-1:0] LAST_Y    = YW'(Y_MAX - 1);
    localparam logic [IW-1:0] LAST_IMG  = IW'(NUM_IMAGES - 1);
    localparam logic [7:0]    DWELL_END = 8'(DWELL_SECONDS);

    state_t        state, state_d;
    logic [XW-1:0] sx, sx_d;
    logic [YW-1:0] sy, sy_d;
    logic          scan_valid;
    logic          wrap;
    logic          load_sel;

    logic [7:0]    dwell;
    logic          advance_pending;
    logic          tick_fire;
    logic          dwell_hit;
    logic          user_any;
    logic          req_set;
    logic [IW-1:0] fwd_sel;
    logic [IW-1:0] pending_sel;

    logic [IW-1:0] sel_d;
    logic          live;

    assign addr_x = sx;
    assign addr_y = sy;

    assign fwd_sel = (image_sel == LAST_IMG) ? '0 : image_sel + 1'b1;

    assign tick_fire = sec_tick & ~pause;
    assign dwell_hit = tick_fire & ((dwell + 8'd1) == DWELL_END);

`ifdef SLIDESHOW_REVERSE_EN
    logic          user_fwd;
    logic          user_rev;
    logic          reverse_dir;
    logic [IW-1:0] rev_sel;

    // Simultaneous next/prev cancel each other, but still reset the dwell.
    assign user_fwd = next_req & ~prev_req;
    assign user_rev = prev_req & ~next_req;
    assign user_any = next_req | prev_req;
    assign req_set  = user_fwd | user_rev | (dwell_hit & ~user_any);
    assign rev_sel  = (image_sel == '0) ? LAST_IMG : image_sel - 1'b1;
    assign pending_sel = reverse_dir ? rev_sel : fwd_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reverse_dir <= 1'b0;
        end else if (user_rev) begin
            reverse_dir <= 1'b1;
        end else if (user_fwd | (dwell_hit & ~user_any)) begin
            reverse_dir <= 1'b0;
        end
    end
`else
    assign user_any    = next_req;
    assign req_set     = next_req | dwell_hit;
    assign pending_sel = fwd_sel;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell <= '0;
        end else if (user_any || dwell_hit) begin
            dwell <= '0;
        end else if (tick_fire) begin
            dwell <= dwell + 8'd1;
        end
    end

    // A request landing in the SWAP cycle survives for the next boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            advance_pending <= 1'b0;
        end else if (load_sel) begin
            advance_pending <= req_set;
        end else if (req_set) begin
            advance_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            image_sel <= '0;
        end else if (load_sel) begin
            image_sel <= pending_sel;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SCAN;
            sx    <= '0;
            sy    <= '0;
        end else begin
            state <= state_d;
            sx    <= sx_d;
            sy    <= sy_d;
        end
    end

    always_comb begin
        state_d    = state;
        sx_d       = sx;
        sy_d       = sy;
        scan_valid = 1'b0;
        load_sel   = 1'b0;
        wrap       = 1'b0;
        unique case (state)
            SCAN: begin
                scan_valid = 1'b1;
                if (sx == LAST_X) begin
                    sx_d = '0;
                    if (sy == LAST_Y) begin
                        sy_d = '0;
                        wrap = 1'b1;
                        if (advance_pending) begin
                            state_d = SWAP;
                        end
                    end else begin
                        sy_d = sy + 1'b1;
                    end
                end else begin
                    sx_d = sx + 1'b1;
                end
            end
            SWAP: begin
                sx_d     = '0;
                sy_d     = '0;
                load_sel = 1'b1;
                state_d  = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Image index travels with the address so a swap never splits a pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
            sel_d      <= '0;
            live       <= 1'b0;
        end else begin
            x          <= sx;
            y          <= sy;
            plot       <= scan_valid;
            frame_done <= wrap;
            sel_d      <= image_sel;
            live       <= 1'b1;
        end
    end

    always_comb begin
        colour = '0;
        if (live) begin
            for (int k = 0; k < NUM_IMAGES; k++) begin
                if (sel_d == IW'(k)) begin
                    colour = rom_data[k*COLOUR_BITS +: COLOUR_BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_slideshow_scanner.sv
// Directed bench for slideshow_scanner on a 4x2 frame, 3 images, 3 s dwell.
module tb_slideshow_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       next_req = 1'b0;
    logic       pause = 1'b0;
    logic [8:0] rom_data = 9'b011_010_001;
    logic [7:0] addr_x;
    logic [6:0] addr_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [1:0] image_sel;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    int nsw;
    int n;

    always #5 clock = ~clock;

    slideshow_scanner #(
        .NUM_IMAGES(3), .X_MAX(4), .Y_MAX(2), .XW(8), .YW(7),
        .COLOUR_BITS(3), .DWELL_SECONDS(3), .IW(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sec_tick(sec_tick),
        .next_req(next_req),
`ifdef SLIDESHOW_REVERSE_EN
        .prev_req(1'b0),
`endif
        .pause(pause),
        .rom_data(rom_data),
        .addr_x(addr_x),
        .addr_y(addr_y),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .image_sel(image_sel),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_swap(input string tag);
        int k;
        k = 0;
        while (plot !== 1'b0 && k < 40) begin
            step();
            k++;
        end
        chk(tag, {31'd0, plot}, 32'd0);
    endtask

    task automatic pulse_tick_count();
        sec_tick = 1'b1;
        step();
        if (plot === 1'b0) nsw++;
        sec_tick = 1'b0;
        step();
        if (plot === 1'b0) nsw++;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_plot", plot, 0);
        chk("rst_colour", colour, 0);
        chk("rst_sel", image_sel, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ax", addr_x, 0);
        reset = 1'b0;

        // free-running scan, no ticks
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("t1_x", x, (i - 1) % 4);
            chk("t1_y", y, ((i - 1) / 4) % 2);
            chk("t1_ax", addr_x, i % 4);
            chk("t1_plot", plot, 1);
            chk("t1_colour", colour, 1);
            chk("t1_sel", image_sel, 0);
            chk("t1_done", frame_done, ((i - 1) % 8 == 7) ? 1 : 0);
        end

        // dwell expiry: ticks sampled at edges 2, 4, 6
        apply_reset();
        step();
        sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
        sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
        sec_tick = 1'b1; step(); sec_tick = 1'b0;
        step();
        step();
        chk("t2_done", frame_done, 1);
        chk("t2_lastx", x, 3);
        chk("t2_lasty", y, 1);
        chk("t2_sel_pre", image_sel, 0);
        step();
        chk("t2_swap_plot", plot, 0);
        chk("t2_swap_x", x, 0);
        chk("t2_swap_y", y, 0);
        chk("t2_swap_colour", colour, 1);
        chk("t2_swap_sel", image_sel, 1);
        chk("t2_swap_done", frame_done, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_x", x, k % 4);
            chk("t2_y", y, k / 4);
            chk("t2_plot", plot, 1);
            chk("t2_colour", colour, 2);
            chk("t2_done", frame_done, (k == 7) ? 1 : 0);
        end

        // advance to image 2, then three requests collapse into one wrap to 0
        next_req = 1'b1; step(); next_req = 1'b0;
        wait_swap("t3_swap1");
        chk("t3_sel2", image_sel, 2);
        step();
        chk("t3_colour3", colour, 3);
        for (int k = 0; k < 3; k++) begin
            next_req = 1'b1; step(); next_req = 1'b0; step();
        end
        wait_swap("t3_swap2");
        chk("t3_sel0", image_sel, 0);
        step();
        chk("t3_colour1", colour, 1);
        nsw = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (plot === 1'b0) nsw++;
        end
        chk("t3_single", nsw, 0);
        chk("t3_sel_hold", image_sel, 0);

        // pause holds dwell
        pause = 1'b1;
        nsw = 0;
        for (int k = 0; k < 5; k++) pulse_tick_count();
        for (int k = 0; k < 10; k++) begin
            step();
            if (plot === 1'b0) nsw++;
        end
        chk("t4_paused", nsw, 0);
        pause = 1'b0;
        pulse_tick_count();
        pulse_tick_count();
        for (int k = 0; k < 10; k++) begin
            step();
            if (plot === 1'b0) nsw++;
        end
        chk("t4_two_ticks", nsw, 0);
        chk("t4_sel_hold", image_sel, 0);
        sec_tick = 1'b1; step(); sec_tick = 1'b0;
        wait_swap("t4_swap");
        chk("t4_sel1", image_sel, 1);

        // asynchronous reset mid-frame at (2,1)
        n = 0;
        while (!(x == 8'd2 && y == 7'd1) && n < 20) begin
            step();
            n++;
        end
        chk("t5_found", (x == 8'd2 && y == 7'd1) ? 1 : 0, 1);
        chk("t5_sel_pre", image_sel, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_x", x, 0);
        chk("t5_y", y, 0);
        chk("t5_plot", plot, 0);
        chk("t5_colour", colour, 0);
        chk("t5_sel", image_sel, 0);
        chk("t5_ax", addr_x, 0);
        chk("t5_ay", addr_y, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        step();
        chk("t5_rx", x, 0);
        chk("t5_ry", y, 0);
        chk("t5_rplot", plot, 1);
        chk("t5_rcolour", colour, 1);
        chk("t5_rsel", image_sel, 0);
        step();
        chk("t5_rx1", x, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
